// File: rtl/wfg_capture_spi.sv
// wfg_capture_spi: SPI slave receiver that deserializes 8/16/24/32-bit words
// from asynchronous SPI pins into a single-entry AXI-stream output register.
// Optional build macro WFG_CAPTURE_SPI_OVF_CNT_EN adds sts_ovf_cnt_o, a
// saturating 8-bit count of words dropped because the output was stalled.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for select to assert while enabled; config is live
// ST_RECV  | shifting bits on logical-sclk rising edges, config latched
// ST_FLUSH | one cycle: completed word is loaded into the output register
module wfg_capture_spi #(
  parameter int unsigned AXIS_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  input  logic                       ctrl_en_q_i,
  input  logic                       cfg_cpol_q_i,
  input  logic                       cfg_lsbfirst_q_i,
  input  logic [1:0]                 cfg_dff_q_i,
  input  logic                       cfg_sspol_q_i,
  input  logic                       wfg_capture_spi_sclk_i,
  input  logic                       wfg_capture_spi_cs_ni,
  input  logic                       wfg_capture_spi_sdi_i,
  output logic                       sts_ovf_o,
`ifdef WFG_CAPTURE_SPI_OVF_CNT_EN
  output logic [7:0]                 sts_ovf_cnt_o,
`endif
  output logic                       sts_frame_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t state_q, state_d;

  // synchronizer bit order: {sclk, cs_n, sdi}
  logic [2:0] sync1_q, sync2_q;
  logic [1:0] prev_q;
  logic       arm_q, arm_d;

  logic       cpol_q, cpol_d;
  logic       lsb_q, lsb_d;
  logic       sspol_q, sspol_d;
  logic [1:0] dff_q, dff_d;
  logic [4:0] cnt_q, cnt_d;

  logic [AXIS_DATA_WIDTH-1:0] sr_q, sr_d;
  logic [AXIS_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [AXIS_DATA_WIDTH-1:0] mask;
  logic                       tvalid_q, tvalid_d;
  logic                       ovf_q, ovf_d;
  logic                       err_q, err_d;

  logic [4:0] preload;
  logic       pol_ss, pol_ck;
  logic       sel_now, sel_prev, sel_rise, sclk_rise, sdi_s;
  logic       load, ovf_clr, drop;

  // Edge and level detection on synchronized pins; polarity is live in idle, latched otherwise
  always_comb begin
    pol_ss    = (state_q == ST_IDLE) ? cfg_sspol_q_i : sspol_q;
    pol_ck    = (state_q == ST_IDLE) ? cfg_cpol_q_i : cpol_q;
    sel_now   = sync2_q[1] ^ ~pol_ss;
    sel_prev  = prev_q[0] ^ ~pol_ss;
    sel_rise  = sel_now & ~sel_prev & arm_q;
    sclk_rise = (sync2_q[2] ^ pol_ck) & ~(prev_q[1] ^ pol_ck);
    sdi_s     = sync2_q[0];
    preload   = {dff_q, 3'b111};
    case (dff_q)
      2'd0:    mask = AXIS_DATA_WIDTH'(32'h0000_00FF);
      2'd1:    mask = AXIS_DATA_WIDTH'(32'h0000_FFFF);
      2'd2:    mask = AXIS_DATA_WIDTH'(32'h00FF_FFFF);
      default: mask = AXIS_DATA_WIDTH'(32'hFFFF_FFFF);
    endcase
  end

  // Receive FSM: next state, shift register, bit counter and config latch
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    cpol_d  = cpol_q;
    lsb_d   = lsb_q;
    sspol_d = sspol_q;
    dff_d   = dff_q;
    err_d   = 1'b0;
    load    = 1'b0;
    ovf_clr = 1'b0;
    // a select already active out of reset must go inactive before it can start a frame
    arm_d   = arm_q | ~sel_now;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q_i && sel_rise) begin
          state_d = ST_RECV;
          cpol_d  = cfg_cpol_q_i;
          lsb_d   = cfg_lsbfirst_q_i;
          sspol_d = cfg_sspol_q_i;
          dff_d   = cfg_dff_q_i;
          cnt_d   = {cfg_dff_q_i, 3'b111};
          sr_d    = '0;
          ovf_clr = 1'b1;
        end
      end
      ST_RECV: begin
        if (!ctrl_en_q_i) begin
          state_d = ST_IDLE;
        end else if (!sel_now) begin
          state_d = ST_IDLE;
          err_d   = (cnt_q != preload);
        end else if (sclk_rise) begin
          if (lsb_q) begin
            sr_d = (sr_q >> 1) | (AXIS_DATA_WIDTH'(sdi_s) << preload);
          end else begin
            sr_d = ((sr_q << 1) | AXIS_DATA_WIDTH'(sdi_s)) & mask;
          end
          if (cnt_q == 5'd0) begin
            state_d = ST_FLUSH;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      ST_FLUSH: begin
        load = 1'b1;
        sr_d = '0;
        if (!ctrl_en_q_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RECV;
          cnt_d   = preload;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register: accept a completed word unless the previous one is stalled
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    ovf_d    = ovf_q;
    drop     = 1'b0;
    if (tvalid_q && wfg_axis_tready_i) tvalid_d = 1'b0;
    if (load) begin
      if (tvalid_q && !wfg_axis_tready_i) begin
        drop  = 1'b1;
        ovf_d = 1'b1;
      end else begin
        tdata_d  = sr_q;
        tvalid_d = 1'b1;
      end
    end
    if (ovf_clr) ovf_d = 1'b0;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sync1_q  <= 3'b010;
      sync2_q  <= 3'b010;
      prev_q   <= 2'b01;
      arm_q    <= 1'b0;
      cpol_q   <= 1'b0;
      lsb_q    <= 1'b0;
      sspol_q  <= 1'b0;
      dff_q    <= 2'd0;
      cnt_q    <= 5'd0;
      sr_q     <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= {wfg_capture_spi_sclk_i, wfg_capture_spi_cs_ni, wfg_capture_spi_sdi_i};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q[2:1];
      arm_q    <= arm_d;
      cpol_q   <= cpol_d;
      lsb_q    <= lsb_d;
      sspol_q  <= sspol_d;
      dff_q    <= dff_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

`ifdef WFG_CAPTURE_SPI_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturating count of dropped words, cleared with the sticky flag
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
    if (ovf_clr) ovf_cnt_d = 8'd0;
  end

  // Dropped-word counter register
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_cnt_q <= 8'd0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign sts_ovf_cnt_o = ovf_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

  assign wfg_axis_tvalid_o = tvalid_q;
  assign wfg_axis_tdata_o  = tdata_q;
  assign sts_ovf_o         = ovf_q;
  assign sts_frame_err_o   = err_q;

endmodule

// File: tb/tb_wfg_capture_spi.sv
// Scoreboard bench for wfg_capture_spi: a serializer drives SPI pins from
// word values, expected words are queued, and a monitor checks every beat.
module tb_wfg_capture_spi;
  localparam int H = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, tready, tvalid, en, cpol, lsb, sspol, sclk, cs_n, sdi, ovf, ferr;
  logic [1:0]  dff;
  logic [31:0] tdata;
`ifdef WFG_CAPTURE_SPI_OVF_CNT_EN
  logic [7:0]  ovf_cnt;
`endif

  int total = 0, bad = 0;
  int beats = 0, pushed = 0, err_pulses = 0;
  bit rand_rdy = 1'b0;
  logic [31:0] exp_q[$];

  wfg_capture_spi #(.AXIS_DATA_WIDTH(32)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .wfg_axis_tready_i      (tready),
    .wfg_axis_tvalid_o      (tvalid),
    .wfg_axis_tdata_o       (tdata),
    .ctrl_en_q_i            (en),
    .cfg_cpol_q_i           (cpol),
    .cfg_lsbfirst_q_i       (lsb),
    .cfg_dff_q_i            (dff),
    .cfg_sspol_q_i          (sspol),
    .wfg_capture_spi_sclk_i (sclk),
    .wfg_capture_spi_cs_ni  (cs_n),
    .wfg_capture_spi_sdi_i  (sdi),
    .sts_ovf_o              (ovf),
`ifdef WFG_CAPTURE_SPI_OVF_CNT_EN
    .sts_ovf_cnt_o          (ovf_cnt),
`endif
    .sts_frame_err_o        (ferr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] d, input logic l, input logic cp, input logic sp);
    dff = d; lsb = l; cpol = cp; sspol = sp;
    sclk = cp; cs_n = ~sp; sdi = 1'b0;
    cyc(6);
  endtask

  task automatic sel(input logic act);
    cs_n = act ? sspol : ~sspol;
  endtask

  // serialize n bits of v in the configured bit order, sampled on logical rising sclk
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      sdi = v[lsb ? i : (n - 1 - i)];
      cyc(H);
      sclk = ~cpol;
      cyc(H);
      sclk = cpol;
    end
  endtask

  function automatic int word_bits();
    return 8 * (int'(dff) + 1);
  endfunction

  // reference: the captured word is the value truncated to the word size
  task automatic send_word(input logic [31:0] v, input bit expect_beat);
    longint unsigned m;
    m = (64'd1 << word_bits()) - 64'd1;
    if (expect_beat) begin
      exp_q.push_back(32'(longint'(v) & m));
      pushed++;
    end
    send_bits(v, word_bits());
  endtask

  task automatic end_frame();
    cyc(H);
    sel(1'b0);
    cyc(2 * H + 4);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) cyc(1);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: scoreboard pop on handshake, hold check under backpressure, error pulse width
  initial begin
    logic pv;
    logic [31:0] pd;
    logic pe;
    pv = 1'b0; pd = '0; pe = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pv) begin
          chk("hold_valid", 32'(tvalid), 32'd1);
          chk("hold_data", tdata, pd);
        end
        if (tvalid && tready) begin
          beats++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_beat: got 0x%08h expected no beat", tdata);
          end else begin
            chk("beat_data", tdata, exp_q.pop_front());
          end
        end
        if (ferr) begin
          err_pulses++;
          if (pe) begin
            total++; bad++;
            $display("FAIL err_width: frame error high for more than one cycle");
          end
        end
        pv = tvalid && !tready;
        pd = tdata;
        pe = ferr;
      end else begin
        pv = 1'b0;
        pe = 1'b0;
      end
    end
  end

  // random backpressure, guaranteed ready at least every fourth cycle
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) begin
        k++;
        tready = ((k % 4) == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int nw;
    rst_n = 1'b0; tready = 1'b1; en = 1'b0;
    cpol = 1'b0; lsb = 1'b0; dff = 2'd3; sspol = 1'b0;
    sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    cyc(3);
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(ferr), 32'd0);
    rst_n = 1'b1;
    cyc(2);
    en = 1'b1;

    // 32-bit MSB-first
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    sel(1'b1); cyc(2 * H);
    send_word(32'hA5C3_0F96, 1'b1);
    end_frame();
    wait_drain();
    chk("t1_ovf", 32'(ovf), 32'd0);

    // byte LSB-first, cpol=1, two words in one frame
    set_cfg(2'd0, 1'b1, 1'b1, 1'b0);
    sel(1'b1); cyc(2 * H);
    send_word(32'h01, 1'b1);
    send_word(32'h80, 1'b1);
    end_frame();
    wait_drain();

    // overflow: second word dropped while stalled
    tready = 1'b0;
    set_cfg(2'd1, 1'b0, 1'b0, 1'b0);
    sel(1'b1); cyc(2 * H);
    send_word(32'h1234, 1'b1);
    send_word(32'h5678, 1'b0);
    end_frame();
    cyc(10);
    chk("ovf_tvalid", 32'(tvalid), 32'd1);
    chk("ovf_tdata", tdata, 32'h1234);
    chk("ovf_flag", 32'(ovf), 32'd1);
`ifdef WFG_CAPTURE_SPI_OVF_CNT_EN
    chk("ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    tready = 1'b1;
    cyc(4);
    chk("ovf_one_beat", 32'(tvalid), 32'd0);
    wait_drain();
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // partial word: frame error, overflow cleared by the frame start
    set_cfg(2'd3, 1'b0, 1'b0, 1'b1);
    sel(1'b1); cyc(2 * H + 4);
    chk("ovf_cleared", 32'(ovf), 32'd0);
`ifdef WFG_CAPTURE_SPI_OVF_CNT_EN
    chk("ovf_cnt_cleared", 32'(ovf_cnt), 32'd0);
`endif
    send_bits($urandom, 13);
    end_frame();
    chk("ferr_count", 32'(err_pulses), 32'd1);
    chk("ferr_no_beat", 32'(tvalid), 32'd0);

    // reset mid-word, then a clean frame
    set_cfg(2'd3, 1'b0, 1'b0, 1'b0);
    sel(1'b1); cyc(2 * H);
    send_bits(32'h1234_5678, 10);
    rst_n = 1'b0; cyc(1); rst_n = 1'b1;
    cyc(8);
    chk("rst_mid_tvalid", 32'(tvalid), 32'd0);
    sel(1'b0); cyc(8);
    sel(1'b1); cyc(2 * H);
    send_word(32'hDEAD_BEEF, 1'b1);
    end_frame();
    wait_drain();
    chk("rst_mid_no_err", 32'(err_pulses), 32'd1);

    // disable mid-frame: no capture even if the remaining bits arrive
    sel(1'b1); cyc(2 * H);
    send_bits($urandom, 9);
    en = 1'b0; cyc(4); en = 1'b1;
    send_bits($urandom, 23);
    end_frame();
    chk("dis_no_err", 32'(err_pulses), 32'd1);
    set_cfg(2'd0, 1'b0, 1'b0, 1'b0);
    sel(1'b1); cyc(2 * H);
    send_word(32'h5A, 1'b1);
    end_frame();
    wait_drain();

    // randomized frames with random backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 20; f++) begin
      set_cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      sel(1'b1); cyc(2 * H);
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        v = $urandom;
        send_word(v, 1'b1);
      end
      end_frame();
      chk("rand_ovf", 32'(ovf), 32'd0);
    end
    rand_rdy = 1'b0;
    tready = 1'b1;
    wait_drain();

    chk("beat_total", 32'(beats), 32'(pushed));
    chk("err_total", 32'(err_pulses), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
